agc_ema_ctrl: RTL and testbench
===============================

Name: agc_ema_ctrl

Overview:
- Sequencing controller in front of the AGC exponential-moving-average filter.
- Gates the magnitude samples into the EMA and drives its coefficient port. Run phases: fast acquisition, then attack/release tracking, plus freeze (hold) and stop.
- Registers the EMA output as a 27-bit level estimate for the downstream gain logic.

Parameters:
- DWIDTH, 27, sample/estimate width (signed, Q.18 fraction).
- BWIDTH, 18, coefficient width (signed Q1.17).
- OUTWIDTH, 48, EMA accumulator width (Q.32 fraction).
- ACQ_LEN, 64, accepted samples spent in ACQUIRE (>=2).
- COEF_FAST, 18'h08000, coefficient in ACQUIRE (0.25).
- COEF_ATTACK, 18'h04000, TRACK coefficient when sample > estimate.
- COEF_RELEASE, 18'h00400, TRACK coefficient when sample <= estimate.
- HYST, 27'd256, hysteresis band (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse: IDLE -> ACQUIRE.
- stop  in  1  pulse: any state -> IDLE.
- freeze  in  1  level: hold the estimate (TRACK <-> HOLD).
- in_data  in  DWIDTH  signed magnitude sample.
- in_valid  in  1  in_data qualifier.
- ema_data  out  DWIDTH  to EMA Port_Data.
- ema_valid  out  1  to EMA Valid.
- ema_coef  out  BWIDTH  to EMA Filter_Coefficient.
- ema_out  in  OUTWIDTH  from EMA Filter_Out.
- ema_out_valid  in  1  from EMA Valid_out_ema.
- est  out  DWIDTH  registered level estimate.
- est_valid  out  1  one-cycle strobe when est updates.
- state  out  2  00 IDLE, 01 ACQUIRE, 10 TRACK, 11 HOLD.
- locked  out  1  high in TRACK or HOLD.

Behaviour:
- Reset values: state=IDLE, ema_valid=0, ema_data=0, ema_coef=COEF_FAST, est=0, est_valid=0, locked=0, acquire counter=0.
- Reset is accepted at any time, including mid-acquisition. The EMA's internal accumulator is not cleared by this block.
- FSM transitions:
  - stop has priority over every other event; on stop the next state is IDLE.
  - IDLE: on start, go to ACQUIRE and load counter = ACQ_LEN-1.
  - ACQUIRE: each accepted sample decrements the counter. The accepted sample that arrives with counter==0 moves the FSM to TRACK.
  - TRACK: freeze=1 moves the FSM to HOLD.
  - HOLD: freeze=0 moves the FSM to TRACK.
  - freeze is ignored in IDLE and ACQUIRE.
  - start is ignored outside IDLE. start and stop in the same cycle: stop wins, FSM stays in or goes to IDLE.
- Sample accept: in_valid=1 and state is ACQUIRE or TRACK. Samples in IDLE or HOLD are dropped (ema_valid stays 0).
- Forwarding (1-cycle latency): an accepted sample at cycle t produces, at t+1:
  - ema_valid=1;
  - ema_data=in_data;
  - ema_coef = the coefficient for that sample.
- ema_coef changes only in the cycle that ema_valid asserts, and holds otherwise. The EMA samples its coefficient alongside the data, so it must never change between strobes.
- Coefficient select:
  - ACQUIRE: COEF_FAST.
  - TRACK: COEF_ATTACK if signed in_data > est, else COEF_RELEASE.
  - The compare uses the est register value in the acceptance cycle.
- Estimate path: on ema_out_valid, est <= ema_out arithmetically shifted right by 14 (34-bit intermediate), saturated to the signed DWIDTH range. est_valid pulses 1 cycle later.
  - Positive overflow gives 2^26-1.
  - Negative overflow gives -2^26.
- est is not updated in IDLE; ema_out_valid is ignored there.
- locked deasserts in the same cycle state leaves TRACK/HOLD.
- Back-to-back in_valid every cycle is supported with no bubbles.

Optional Feature:
- Macro: AGC_EMA_HYST_EN.
- Defined: TRACK selects COEF_ATTACK only if in_data > est+HYST, and COEF_RELEASE only if in_data < est-HYST. Otherwise the previous ema_coef is kept. Additions saturate to the DWIDTH range.
- Not defined: plain compare as above; HYST is unused.

Test Plan:
- Reset/idle: assert rst mid-stream, then feed in_valid with in_data=1000 for 10 cycles -> state=00, ema_valid never 1, ema_coef=18'h08000, est=0.
- Acquire length: pulse start, then 64 samples of 27'd4096 every cycle -> 64 ema_valid strobes with coef 18'h08000. state=10 on the cycle after the 64th accept; the 65th sample carries COEF_ATTACK or COEF_RELEASE per the compare.
- Attack/release: in TRACK with est=4096, feed in_data=8192 -> ema_coef=18'h04000; feed in_data=2048 -> ema_coef=18'h00400; feed in_data=4096 -> 18'h00400.
- Freeze: in TRACK, freeze=1 for 20 cycles with continuous in_valid -> state=11, no ema_valid, est constant, locked=1. Release freeze -> TRACK next cycle, forwarding resumes.
- Estimate saturation: drive ema_out=48'h7FFF_FFFF_FFFF with ema_out_valid -> est=27'h3FFFFFF. Drive ema_out=48'h0000_1000_0000 -> est=27'd16384.
- Stop priority: start and stop in the same cycle from IDLE -> stays IDLE. stop during ACQUIRE at count 30 -> IDLE next cycle. A later start reloads the full 64-sample acquire.

Source files
------------

// File: rtl/agc_ema_ctrl_if.sv
// Bus between the AGC EMA sequencing controller and its surroundings:
// control pulses, the magnitude sample stream, the EMA filter port pair,
// and the registered level estimate. The controller uses the slave modport;
// whoever drives the samples and the EMA model uses the master modport.
interface agc_ema_ctrl_if #(
  parameter int DWIDTH   = 27,
  parameter int BWIDTH   = 18,
  parameter int OUTWIDTH = 48
);
  logic                       start;
  logic                       stop;
  logic                       freeze;
  logic signed [DWIDTH-1:0]   in_data;
  logic                       in_valid;
  logic signed [DWIDTH-1:0]   ema_data;
  logic                       ema_valid;
  logic        [BWIDTH-1:0]   ema_coef;
  logic signed [OUTWIDTH-1:0] ema_out;
  logic                       ema_out_valid;
  logic signed [DWIDTH-1:0]   est;
  logic                       est_valid;
  logic        [1:0]          state;
  logic                       locked;

  modport slave (
    input  start, stop, freeze, in_data, in_valid, ema_out, ema_out_valid,
    output ema_data, ema_valid, ema_coef, est, est_valid, state, locked
  );

  modport master (
    output start, stop, freeze, in_data, in_valid, ema_out, ema_out_valid,
    input  ema_data, ema_valid, ema_coef, est, est_valid, state, locked
  );
endinterface

// File: rtl/agc_ema_ctrl.sv
// Sequencing controller in front of the AGC exponential-moving-average
// filter. Gates magnitude samples into the EMA with a one-cycle forward
// latency, picks the EMA coefficient (fast acquisition, then attack/release
// tracking), and registers the rescaled EMA output as the level estimate.
//
// Optional build macro AGC_EMA_HYST_EN: adds a hysteresis band of HYST
// around the estimate for the attack/release decision; inside the band the
// previous coefficient is kept.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE (00) | stopped, samples dropped, EMA output ignored
// ACQUIRE(01)| ACQ_LEN accepted samples forwarded with COEF_FAST
// TRACK (10)| samples forwarded with attack or release coefficient
// HOLD  (11)| frozen: samples dropped, estimate held from the filter side
module agc_ema_ctrl #(
  parameter int                 DWIDTH       = 27,
  parameter int                 BWIDTH       = 18,
  parameter int                 OUTWIDTH     = 48,
  parameter int                 ACQ_LEN      = 64,
  parameter logic [BWIDTH-1:0]  COEF_FAST    = 18'h08000,
  parameter logic [BWIDTH-1:0]  COEF_ATTACK  = 18'h04000,
  parameter logic [BWIDTH-1:0]  COEF_RELEASE = 18'h00400,
  parameter logic [DWIDTH-1:0]  HYST         = 27'd256
) (
  input  logic                  clk,
  input  logic                  rst,
  agc_ema_ctrl_if.slave         bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACQUIRE = 2'b01,
    S_TRACK   = 2'b10,
    S_HOLD    = 2'b11
  } state_t;

  localparam int CW  = (ACQ_LEN > 1) ? $clog2(ACQ_LEN) : 1;
  // EMA output is Q.32, the estimate Q.18: drop 14 fraction bits.
  localparam int SHW = OUTWIDTH - 14;
  localparam logic signed [DWIDTH-1:0] EST_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic signed [DWIDTH-1:0] EST_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     accept;
  logic [BWIDTH-1:0]        coef_sel;
  logic                     ema_valid_q;
  logic signed [DWIDTH-1:0] ema_data_q;
  logic [BWIDTH-1:0]        ema_coef_q;
  logic signed [DWIDTH-1:0] est_q;
  logic                     est_valid_q;
  logic signed [SHW-1:0]    est_shift;
  logic                     est_fits;
  logic signed [DWIDTH-1:0] est_sat;
  logic                     est_load;
  logic                     unused_ema_lsbs;

  assign accept = bus.in_valid && ((state_q == S_ACQUIRE) || (state_q == S_TRACK));

  // State register and acquire down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; stop overrides everything, including start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_ACQUIRE;
            cnt_d   = CW'(ACQ_LEN - 1);
          end
        end
        S_ACQUIRE: begin
          if (bus.in_valid) begin
            if (cnt_q == '0) state_d = S_TRACK;
            else             cnt_d   = cnt_q - 1'b1;
          end
        end
        S_TRACK: if (bus.freeze)  state_d = S_HOLD;
        S_HOLD:  if (!bus.freeze) state_d = S_TRACK;
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef AGC_EMA_HYST_EN
  logic signed [DWIDTH:0]   est_hi_w, est_lo_w;
  logic signed [DWIDTH-1:0] est_hi, est_lo;

  assign est_hi_w = {est_q[DWIDTH-1], est_q} + $signed({1'b0, HYST});
  assign est_lo_w = {est_q[DWIDTH-1], est_q} - $signed({1'b0, HYST});

  // Band edges clamp to the estimate range so the compare never wraps.
  always_comb begin
    est_hi = est_hi_w[DWIDTH-1:0];
    est_lo = est_lo_w[DWIDTH-1:0];
    if (est_hi_w[DWIDTH] != est_hi_w[DWIDTH-1])
      est_hi = est_hi_w[DWIDTH] ? EST_MIN : EST_MAX;
    if (est_lo_w[DWIDTH] != est_lo_w[DWIDTH-1])
      est_lo = est_lo_w[DWIDTH] ? EST_MIN : EST_MAX;
  end
`endif

  // Coefficient for the sample being accepted this cycle.
  always_comb begin
    coef_sel = ema_coef_q;
    if (state_q == S_ACQUIRE) begin
      coef_sel = COEF_FAST;
    end else begin
`ifdef AGC_EMA_HYST_EN
      if (bus.in_data > est_hi)      coef_sel = COEF_ATTACK;
      else if (bus.in_data < est_lo) coef_sel = COEF_RELEASE;
`else
      if (bus.in_data > est_q) coef_sel = COEF_ATTACK;
      else                     coef_sel = COEF_RELEASE;
`endif
    end
  end

`ifndef AGC_EMA_HYST_EN
  logic unused_hyst;
  assign unused_hyst = ^HYST;
`endif

  // Forward accepted samples; data and coefficient only move with the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ema_valid_q <= 1'b0;
      ema_data_q  <= '0;
      ema_coef_q  <= COEF_FAST;
    end else begin
      ema_valid_q <= accept;
      if (accept) begin
        ema_data_q <= bus.in_data;
        ema_coef_q <= coef_sel;
      end
    end
  end

  assign est_shift       = bus.ema_out[OUTWIDTH-1:14];
  assign unused_ema_lsbs = ^bus.ema_out[13:0];
  assign est_fits        = (&est_shift[SHW-1:DWIDTH-1]) || (~|est_shift[SHW-1:DWIDTH-1]);
  assign est_sat         = est_fits ? est_shift[DWIDTH-1:0]
                                    : (est_shift[SHW-1] ? EST_MIN : EST_MAX);
  assign est_load        = bus.ema_out_valid && (state_q != S_IDLE);

  // Capture the rescaled, saturated EMA output as the level estimate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est_q       <= '0;
      est_valid_q <= 1'b0;
    end else begin
      est_valid_q <= est_load;
      if (est_load) est_q <= est_sat;
    end
  end

  assign bus.ema_valid = ema_valid_q;
  assign bus.ema_data  = ema_data_q;
  assign bus.ema_coef  = ema_coef_q;
  assign bus.est       = est_q;
  assign bus.est_valid = est_valid_q;
  assign bus.state     = state_q;
  assign bus.locked    = (state_q == S_TRACK) || (state_q == S_HOLD);

endmodule

// File: tb/tb_agc_ema_ctrl.sv
// Bench for agc_ema_ctrl: directed stimulus, a behavioural reference model
// that is checked against the DUT every cycle, and literal expectations
// for the key scenarios.
module tb_agc_ema_ctrl;
  localparam int ACQ_LEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   n_strobe = 0;
  int   n_fast = 0;
  int   s0, f0;

  agc_ema_ctrl_if bus ();

  agc_ema_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: states 0 idle, 1 acquire, 2 track, 3 hold;
  // m_cnt counts samples already taken during acquisition.
  int                m_state;
  int                m_cnt;
  logic              m_ev;
  logic signed [26:0] m_ed;
  logic [17:0]       m_coef;
  logic signed [26:0] m_est;
  logic              m_estv;

  function automatic logic m_accept();
    return bus.in_valid && (m_state == 1 || m_state == 2);
  endfunction

  function automatic int m_next();
    if (bus.stop) return 0;
    case (m_state)
      0:       return bus.start ? 1 : 0;
      1:       return (bus.in_valid && m_cnt == ACQ_LEN - 1) ? 2 : 1;
      default: return bus.freeze ? 3 : 2;
    endcase
  endfunction

  function automatic logic [17:0] m_pick();
    if (m_state == 1) return 18'h08000;
`ifdef AGC_EMA_HYST_EN
    if (int'(bus.in_data) > int'(m_est) + 256) return 18'h04000;
    if (int'(bus.in_data) < int'(m_est) - 256) return 18'h00400;
    return m_coef;
`else
    return (int'(bus.in_data) > int'(m_est)) ? 18'h04000 : 18'h00400;
`endif
  endfunction

  function automatic logic signed [26:0] m_sat(input logic [47:0] eo);
    longint v;
    v = $signed(eo);
    v = v >>> 14;
    if (v > 64'sd67108863)  return 27'h3FFFFFF;
    if (v < -64'sd67108864) return 27'h4000000;
    return v[26:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_ev    <= 1'b0;
      m_ed    <= '0;
      m_coef  <= 18'h08000;
      m_est   <= '0;
      m_estv  <= 1'b0;
    end else begin
      m_ev <= m_accept();
      if (m_accept()) begin
        m_ed   <= bus.in_data;
        m_coef <= m_pick();
      end
      if (bus.ema_out_valid && m_state != 0) m_est <= m_sat(bus.ema_out);
      m_estv  <= bus.ema_out_valid && (m_state != 0);
      m_state <= m_next();
      if (m_state == 0 && bus.start && !bus.stop) m_cnt <= 0;
      else if (m_state == 1 && bus.in_valid && !bus.stop) m_cnt <= m_cnt + 1;
    end
  end

  // Every-cycle comparison against the model, plus strobe counters.
  always @(negedge clk) begin
    if (!rst) begin
      check("state",     {62'd0, bus.state}, 64'(m_state));
      check("locked",    {63'd0, bus.locked}, {63'd0, (m_state >= 2)});
      check("ema_valid", {63'd0, bus.ema_valid}, {63'd0, m_ev});
      check("ema_coef",  {46'd0, bus.ema_coef}, {46'd0, m_coef});
      if (m_ev) check("ema_data", {37'd0, bus.ema_data}, {37'd0, m_ed});
      check("est",       {37'd0, bus.est}, {37'd0, m_est});
      check("est_valid", {63'd0, bus.est_valid}, {63'd0, m_estv});
      if (bus.ema_valid) n_strobe <= n_strobe + 1;
      if (bus.ema_valid && bus.ema_coef == 18'h08000) n_fast <= n_fast + 1;
    end
  end

  initial begin
    bus.start = 0; bus.stop = 0; bus.freeze = 0;
    bus.in_data = '0; bus.in_valid = 0;
    bus.ema_out = '0; bus.ema_out_valid = 0;
    repeat (2) tick();
    rst = 0;
    tick();
    check("rst_state", {62'd0, bus.state}, 64'd0);
    check("rst_coef",  {46'd0, bus.ema_coef}, 64'h08000);
    check("rst_est",   {37'd0, bus.est}, 64'd0);

    // Reset in the middle of an acquisition, then samples in IDLE.
    bus.start = 1; tick(); bus.start = 0;
    bus.in_valid = 1; bus.in_data = 27'd1000;
    repeat (5) tick();
    rst = 1; tick(); rst = 0;
    s0 = n_strobe;
    repeat (10) tick();
    check("idle_state",   {62'd0, bus.state}, 64'd0);
    check("idle_strobes", 64'(n_strobe - s0), 64'd0);
    check("idle_coef",    {46'd0, bus.ema_coef}, 64'h08000);
    check("idle_est",     {37'd0, bus.est}, 64'd0);

    // Full acquisition: 64 samples with the fast coefficient.
    bus.in_valid = 0;
    bus.start = 1; tick(); bus.start = 0;
    check("acq_enter", {62'd0, bus.state}, 64'd1);
    s0 = n_strobe; f0 = n_fast;
    bus.in_valid = 1; bus.in_data = 27'd4096;
    repeat (63) tick();
    check("acq_63", {62'd0, bus.state}, 64'd1);
    tick();
    check("acq_done",   {62'd0, bus.state}, 64'd2);
    check("acq_locked", {63'd0, bus.locked}, 64'd1);
    tick();
    check("first_track_valid", {63'd0, bus.ema_valid}, 64'd1);
    check("first_track_coef",  {46'd0, bus.ema_coef}, 64'h04000);
    bus.in_valid = 0;
    tick();
    check("acq_strobes", 64'(n_strobe - s0), 64'd65);
    check("acq_fast",    64'(n_fast - f0), 64'd64);

    // Attack/release with est = 4096.
    bus.ema_out = 48'h0000_0400_0000; bus.ema_out_valid = 1;
    tick(); bus.ema_out_valid = 0;
    check("est_4096",    {37'd0, bus.est}, 64'd4096);
    check("est_strobe",  {63'd0, bus.est_valid}, 64'd1);
    bus.in_valid = 1;
    bus.in_data = 27'd8192; tick();
    check("attack", {46'd0, bus.ema_coef}, 64'h04000);
    bus.in_data = 27'd2048; tick();
    check("release", {46'd0, bus.ema_coef}, 64'h00400);
    bus.in_data = 27'd4096; tick();
    check("equal_release", {46'd0, bus.ema_coef}, 64'h00400);
    bus.in_valid = 0;
    tick();

    // Freeze: HOLD for 20 cycles with samples offered.
    bus.freeze = 1; tick();
    check("hold_enter", {62'd0, bus.state}, 64'd3);
    bus.in_valid = 1; bus.in_data = 27'd5000;
    s0 = n_strobe;
    repeat (20) tick();
    check("hold_state",   {62'd0, bus.state}, 64'd3);
    check("hold_locked",  {63'd0, bus.locked}, 64'd1);
    check("hold_est",     {37'd0, bus.est}, 64'd4096);
    check("hold_strobes", 64'(n_strobe - s0), 64'd0);
    bus.freeze = 0; tick();
    check("unfreeze", {62'd0, bus.state}, 64'd2);
    tick();
    check("resume_valid", {63'd0, bus.ema_valid}, 64'd1);
    check("resume_data",  {37'd0, bus.ema_data}, 64'd5000);
    check("resume_coef",  {46'd0, bus.ema_coef}, 64'h04000);
    bus.in_valid = 0;

    // Estimate saturation and scaling.
    bus.ema_out_valid = 1;
    bus.ema_out = 48'h7FFF_FFFF_FFFF; tick();
    check("sat_pos", {37'd0, bus.est}, 64'h3FFFFFF);
    bus.ema_out = 48'h0000_1000_0000; tick();
    check("est_16384", {37'd0, bus.est}, 64'd16384);
    bus.ema_out = 48'h8000_0000_0000; tick();
    check("sat_neg", {37'd0, bus.est}, 64'h4000000);
    bus.ema_out_valid = 0;
    tick();

    // Stop priority and reacquisition.
    bus.stop = 1; tick(); bus.stop = 0;
    check("stop_state",  {62'd0, bus.state}, 64'd0);
    check("stop_locked", {63'd0, bus.locked}, 64'd0);
    bus.ema_out = 48'h0000_0400_0000; bus.ema_out_valid = 1; tick();
    bus.ema_out_valid = 0;
    check("idle_est_hold",   {37'd0, bus.est}, 64'h4000000);
    check("idle_est_strobe", {63'd0, bus.est_valid}, 64'd0);
    bus.start = 1; bus.stop = 1; tick(); bus.stop = 0;
    check("start_stop", {62'd0, bus.state}, 64'd0);
    tick(); bus.start = 0;
    check("restart", {62'd0, bus.state}, 64'd1);
    bus.in_valid = 1; bus.in_data = 27'd300;
    repeat (33) tick();
    bus.in_valid = 0;
    bus.stop = 1; tick(); bus.stop = 0;
    check("stop_in_acq", {62'd0, bus.state}, 64'd0);
    bus.start = 1; tick(); bus.start = 0;
    bus.in_valid = 1;
    repeat (63) tick();
    check("reacq_63", {62'd0, bus.state}, 64'd1);
    tick();
    check("reacq_done", {62'd0, bus.state}, 64'd2);
    bus.in_valid = 0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
